// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared defaults and types for the VRAM arbiter
package vga_pkg;

  localparam int VGA_ADDR_W       = 19;
  localparam int VGA_FRAME_PIXELS = 307200;
  localparam int VGA_FIFO_DEPTH   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fill_state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_DISP  = 2'd1,
    GNT_CLEAR = 2'd2,
    GNT_HOST  = 2'd3
  } grant_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - host write buffer, in-order, refuses push when full
module vram_wr_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full buffer refuses a push even when the same cycle pops an entry.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Entry storage; no reset needed since the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port pixel RAM arbiter: scanout > frame fill > host writes
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = VGA_ADDR_W,
  parameter int FRAME_PIXELS = VGA_FRAME_PIXELS,
  parameter int FIFO_DEPTH   = VGA_FIFO_DEPTH
) (
  input  logic              PIX_CLK,
  input  logic              RST_N,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic [7:0]        DISP_DATA,
  output logic              DISP_VALID,
  input  logic              HOST_VALID,
  output logic              HOST_READY,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [7:0]        HOST_WDATA,
  input  logic              CLEAR_START,
  input  logic [7:0]        CLEAR_COLOR,
  output logic              CLEAR_BUSY,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  input  logic [7:0]        MEM_RDATA
);

  localparam int ENTRY_W = ADDR_W + 8;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  fill_state_t        state;
  grant_t             grant;
  logic [ADDR_W-1:0]  fill_addr;
  logic [7:0]         fill_color;
  logic               fill_last;
  logic               rst_done;
  logic               rd_pend;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_rdata;

  // Ready comes from the registered occupancy and stays low until reset has been released.
  assign HOST_READY = rst_done & (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push       = HOST_VALID & HOST_READY & ~fifo_full;

  vram_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (PIX_CLK),
    .rst_n     (RST_N),
    .push      (push),
    .push_data ({HOST_ADDR, HOST_WDATA}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fixed-priority grant for the next RAM cycle; buffered host writes wait out a fill.
  always_comb begin
    grant = GNT_NONE;
    if (DISP_REQ) begin
      grant = GNT_DISP;
    end else if (state == ST_CLEAR) begin
      grant = GNT_CLEAR;
    end else if (!fifo_empty) begin
      grant = GNT_HOST;
    end
  end

  assign pop       = (grant == GNT_HOST);
  assign fill_last = (grant == GNT_CLEAR) && (fill_addr == LAST_ADDR);

  // Marks the first cycle after reset release so HOST_READY can rise.
  always_ff @(posedge PIX_CLK) begin
    if (!RST_N) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // Fill FSM; CLEAR_BUSY covers the cycle the last fill write is on the RAM bus.
  always_ff @(posedge PIX_CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      fill_addr  <= '0;
      fill_color <= '0;
      CLEAR_BUSY <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CLEAR_START && !CLEAR_BUSY) begin
            state      <= ST_CLEAR;
            fill_addr  <= '0;
            fill_color <= CLEAR_COLOR;
            CLEAR_BUSY <= 1'b1;
          end else begin
            CLEAR_BUSY <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (fill_last) begin
            state     <= ST_IDLE;
            fill_addr <= '0;
          end else if (grant == GNT_CLEAR) begin
            fill_addr <= fill_addr + ADDR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered RAM port: the grant decided this cycle drives the RAM next cycle.
  always_ff @(posedge PIX_CLK) begin
    if (!RST_N) begin
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      case (grant)
        GNT_DISP: begin
          MEM_EN    <= 1'b1;
          MEM_WE    <= 1'b0;
          MEM_ADDR  <= DISP_ADDR;
          MEM_WDATA <= '0;
        end
        GNT_CLEAR: begin
          MEM_EN    <= 1'b1;
          MEM_WE    <= 1'b1;
          MEM_ADDR  <= fill_addr;
          MEM_WDATA <= fill_color;
        end
        GNT_HOST: begin
          MEM_EN    <= 1'b1;
          MEM_WE    <= 1'b1;
          MEM_ADDR  <= fifo_rdata[ENTRY_W-1:8];
          MEM_WDATA <= fifo_rdata[7:0];
        end
        default: begin
          MEM_EN <= 1'b0;
          MEM_WE <= 1'b0;
        end
      endcase
    end
  end

  // Scanout return path: track the read through the RAM's one-cycle latency, then capture it.
  always_ff @(posedge PIX_CLK) begin
    if (!RST_N) begin
      rd_pend    <= 1'b0;
      DISP_VALID <= 1'b0;
      DISP_DATA  <= '0;
    end else begin
      rd_pend    <= MEM_EN & ~MEM_WE;
      DISP_VALID <= rd_pend;
      if (rd_pend) begin
        DISP_DATA <= MEM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

  localparam int ADDR_W       = 10;
  localparam int FRAME_PIXELS = 16;
  localparam int FIFO_DEPTH   = 4;
  localparam int RAM_SIZE     = 1 << ADDR_W;

  logic              PIX_CLK = 1'b0;
  logic              RST_N;
  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic [7:0]        DISP_DATA;
  logic              DISP_VALID;
  logic              HOST_VALID;
  logic              HOST_READY;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [7:0]        HOST_WDATA;
  logic              CLEAR_START;
  logic [7:0]        CLEAR_COLOR;
  logic              CLEAR_BUSY;
  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic [7:0]        MEM_RDATA = 8'h00;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]        ram     [RAM_SIZE];
  logic [7:0]        ref_ram [RAM_SIZE];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];
  int                wr_cyc_q[$];

  vram_arbiter #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FRAME_PIXELS),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .PIX_CLK     (PIX_CLK),
    .RST_N       (RST_N),
    .DISP_REQ    (DISP_REQ),
    .DISP_ADDR   (DISP_ADDR),
    .DISP_DATA   (DISP_DATA),
    .DISP_VALID  (DISP_VALID),
    .HOST_VALID  (HOST_VALID),
    .HOST_READY  (HOST_READY),
    .HOST_ADDR   (HOST_ADDR),
    .HOST_WDATA  (HOST_WDATA),
    .CLEAR_START (CLEAR_START),
    .CLEAR_COLOR (CLEAR_COLOR),
    .CLEAR_BUSY  (CLEAR_BUSY),
    .MEM_EN      (MEM_EN),
    .MEM_WE      (MEM_WE),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_RDATA   (MEM_RDATA)
  );

  always #5 PIX_CLK = ~PIX_CLK;

  // Single-port RAM with one-cycle read latency, plus a log of every write it receives.
  always @(posedge PIX_CLK) begin
    if (MEM_EN && MEM_WE) begin
      ram[MEM_ADDR] = MEM_WDATA;
      wr_addr_q.push_back(MEM_ADDR);
      wr_data_q.push_back(MEM_WDATA);
      wr_cyc_q.push_back(cyc);
    end else if (MEM_EN) begin
      MEM_RDATA <= ram[MEM_ADDR];
    end
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge PIX_CLK);
    #1;
  endtask

  task automatic idle_inputs();
    DISP_REQ    = 1'b0;
    DISP_ADDR   = '0;
    HOST_VALID  = 1'b0;
    HOST_ADDR   = '0;
    HOST_WDATA  = '0;
    CLEAR_START = 1'b0;
    CLEAR_COLOR = '0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic test_reset();
    logic [ADDR_W+19:0] obs;
    idle_inputs();
    RST_N    = 1'b0;
    DISP_REQ = 1'b1;
    step();
    step();
    obs = {MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, DISP_VALID, DISP_DATA, CLEAR_BUSY, HOST_READY};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", obs);
    end
    DISP_REQ = 1'b0;
    RST_N    = 1'b1;
    step();
    vectors++;
    if (HOST_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset got %b want 1", HOST_READY);
    end
    repeat (3) step();
  endtask

  task automatic test_disp_read();
    ram[10'h100]     = 8'hA5;
    ref_ram[10'h100] = 8'hA5;
    DISP_REQ  = 1'b1;
    DISP_ADDR = 10'h100;
    step();
    DISP_REQ = 1'b0;
    step();
    vectors++;
    if (DISP_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL disp_early got valid %b want 0", DISP_VALID);
    end
    step();
    vectors++;
    if (DISP_VALID !== 1'b1 || DISP_DATA !== 8'hA5) begin
      miscompares++;
      $display("FAIL disp_read got valid %b data %h want 1 a5", DISP_VALID, DISP_DATA);
    end
    repeat (3) step();
  endtask

  task automatic test_random_reads();
    logic       exp_v [0:63];
    logic [7:0] exp_d [0:63];
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 64; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 8'h00;
    end
    for (int i = 0; i < 256; i++) begin
      a          = ADDR_W'(32'h100 + i);
      ram[a]     = 8'($urandom);
      ref_ram[a] = ram[a];
    end
    for (int k = 0; k < 42; k++) begin
      if (k < 40) begin
        DISP_REQ  = 1'($urandom_range(0, 1));
        DISP_ADDR = ADDR_W'(32'h100 + $urandom_range(0, 255));
        if (DISP_REQ) begin
          exp_v[k+2] = 1'b1;
          exp_d[k+2] = ref_ram[DISP_ADDR];
        end
      end else begin
        DISP_REQ = 1'b0;
      end
      step();
      vectors++;
      if (DISP_VALID !== exp_v[k] || (exp_v[k] && DISP_DATA !== exp_d[k])) begin
        miscompares++;
        $display("FAIL rand_read k=%0d got %b/%h want %b/%h", k, DISP_VALID, DISP_DATA, exp_v[k], exp_d[k]);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_fifo_full();
    logic [ADDR_W-1:0] qa[$];
    logic [7:0]        qd[$];
    logic              exp_rdy;
    clear_log();
    DISP_REQ  = 1'b1;
    DISP_ADDR = 10'h100;
    for (int j = 0; j < 5; j++) begin
      HOST_VALID = 1'b1;
      HOST_ADDR  = ADDR_W'(32'h200 + j);
      HOST_WDATA = 8'($urandom);
      exp_rdy    = (j < FIFO_DEPTH);
      vectors++;
      if (HOST_READY !== exp_rdy) begin
        miscompares++;
        $display("FAIL fifo_ready j=%0d got %b want %b", j, HOST_READY, exp_rdy);
      end
      if (exp_rdy) begin
        qa.push_back(HOST_ADDR);
        qd.push_back(HOST_WDATA);
      end
      step();
    end
    HOST_VALID = 1'b0;
    vectors++;
    if (wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL fifo_no_drain_under_disp got %0d writes want 0", wr_addr_q.size());
    end
    DISP_REQ = 1'b0;
    repeat (6) step();
    vectors++;
    if (wr_addr_q.size() != 4) begin
      miscompares++;
      $display("FAIL fifo_drain_count got %0d want 4", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wr_addr_q[i] !== qa[i] || wr_data_q[i] !== qd[i] || wr_cyc_q[i] != wr_cyc_q[0] + i) begin
          miscompares++;
          $display("FAIL fifo_drain_order i=%0d got %h/%h cyc+%0d want %h/%h cyc+%0d",
                   i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - wr_cyc_q[0], qa[i], qd[i], i);
        end
        ref_ram[qa[i]] = qd[i];
      end
    end
    vectors++;
    if (HOST_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_ready_after_drain got %b want 1", HOST_READY);
    end
    repeat (3) step();
  endtask

  task automatic test_random_host();
    logic [ADDR_W-1:0] qa[$];
    logic [7:0]        qd[$];
    int                model_cnt;
    logic              exp_rdy;
    logic              do_push;
    logic              do_pop;
    model_cnt = 0;
    clear_log();
    for (int k = 0; k < 80; k++) begin
      HOST_VALID = 1'($urandom_range(0, 1));
      HOST_ADDR  = ADDR_W'(32'h200 + $urandom_range(0, 255));
      HOST_WDATA = 8'($urandom);
      DISP_REQ   = ($urandom_range(0, 2) == 0);
      DISP_ADDR  = ADDR_W'(32'h100 + $urandom_range(0, 255));
      exp_rdy    = (model_cnt < FIFO_DEPTH);
      vectors++;
      if (HOST_READY !== exp_rdy) begin
        miscompares++;
        $display("FAIL rand_host_ready k=%0d got %b want %b", k, HOST_READY, exp_rdy);
      end
      do_push = HOST_VALID && exp_rdy;
      do_pop  = !DISP_REQ && model_cnt > 0;
      if (do_push) begin
        qa.push_back(HOST_ADDR);
        qd.push_back(HOST_WDATA);
      end
      model_cnt = model_cnt + int'(do_push) - int'(do_pop);
      step();
    end
    idle_inputs();
    repeat (8) step();
    vectors++;
    if (wr_addr_q.size() != qa.size()) begin
      miscompares++;
      $display("FAIL rand_host_count got %0d want %0d", wr_addr_q.size(), qa.size());
    end else begin
      for (int i = 0; i < qa.size(); i++) begin
        vectors++;
        if (wr_addr_q[i] !== qa[i] || wr_data_q[i] !== qd[i]) begin
          miscompares++;
          $display("FAIL rand_host_order i=%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], qa[i], qd[i]);
        end
        ref_ram[qa[i]] = qd[i];
      end
    end
    repeat (3) step();
  endtask

  task automatic test_clear();
    logic done;
    done = 1'b0;
    clear_log();
    CLEAR_START = 1'b1;
    CLEAR_COLOR = 8'hE0;
    step();
    CLEAR_START = 1'b0;
    CLEAR_COLOR = 8'h00;
    vectors++;
    if (CLEAR_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_busy_rise got %b want 1", CLEAR_BUSY);
    end
    for (int k = 0; k < 40 && !done; k++) begin
      CLEAR_START = (k == 5);
      CLEAR_COLOR = (k == 5) ? 8'h1F : 8'h00;
      step();
      vectors++;
      if (CLEAR_BUSY !== (wr_addr_q.size() < FRAME_PIXELS)) begin
        miscompares++;
        $display("FAIL clear_busy k=%0d got %b with %0d writes", k, CLEAR_BUSY, wr_addr_q.size());
      end
      if (!CLEAR_BUSY) done = 1'b1;
    end
    CLEAR_START = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL clear_timeout busy still %b want 0", CLEAR_BUSY);
    end
    repeat (3) step();
    vectors++;
    if (wr_addr_q.size() != FRAME_PIXELS) begin
      miscompares++;
      $display("FAIL clear_count got %0d want %0d", wr_addr_q.size(), FRAME_PIXELS);
    end else begin
      for (int i = 0; i < FRAME_PIXELS; i++) begin
        vectors++;
        if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== 8'hE0) begin
          miscompares++;
          $display("FAIL clear_write i=%0d got %h/%h want %h/e0", i, wr_addr_q[i], wr_data_q[i], i);
        end
      end
    end
    for (int i = 0; i < FRAME_PIXELS; i++) ref_ram[i] = 8'hE0;
  endtask

  task automatic test_host_during_fill();
    logic done;
    done = 1'b0;
    CLEAR_START = 1'b1;
    CLEAR_COLOR = 8'h1C;
    step();
    CLEAR_START = 1'b0;
    step();
    HOST_VALID = 1'b1;
    HOST_ADDR  = 10'h003;
    HOST_WDATA = 8'h07;
    vectors++;
    if (HOST_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_host_ready got %b want 1", HOST_READY);
    end
    step();
    HOST_VALID = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      if (!CLEAR_BUSY) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL fill_host_timeout busy %b want 0", CLEAR_BUSY);
    end
    for (int i = 0; i < FRAME_PIXELS; i++) ref_ram[i] = 8'h1C;
    ref_ram[3] = 8'h07;
    repeat (4) step();
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      DISP_REQ  = 1'b1;
      DISP_ADDR = ADDR_W'(i);
      step();
      DISP_REQ = 1'b0;
      step();
      step();
      vectors++;
      if (DISP_VALID !== 1'b1 || DISP_DATA !== ref_ram[i]) begin
        miscompares++;
        $display("FAIL fill_host_readback addr %0d got %b/%h want 1/%h", i, DISP_VALID, DISP_DATA, ref_ram[i]);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_fill_with_display();
    logic       exp_v [0:63];
    logic [7:0] exp_d [0:63];
    int         fill_idx;
    fill_idx = 0;
    for (int i = 0; i < 64; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 8'h00;
    end
    CLEAR_START = 1'b1;
    CLEAR_COLOR = 8'h33;
    step();
    CLEAR_START = 1'b0;
    for (int k = 0; k < 40; k++) begin
      DISP_REQ  = (k < 36) && (k % 2 == 0);
      DISP_ADDR = ADDR_W'(32'h100 + $urandom_range(0, 255));
      if (DISP_REQ) begin
        exp_v[k+2] = 1'b1;
        exp_d[k+2] = ref_ram[DISP_ADDR];
      end
      step();
      vectors++;
      if (DISP_REQ) begin
        if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== DISP_ADDR) begin
          miscompares++;
          $display("FAIL fill_disp_bus k=%0d got en%b we%b %h want read %h", k, MEM_EN, MEM_WE, MEM_ADDR, DISP_ADDR);
        end
      end else if (fill_idx < FRAME_PIXELS) begin
        if (MEM_EN !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== ADDR_W'(fill_idx) || MEM_WDATA !== 8'h33) begin
          miscompares++;
          $display("FAIL fill_step_bus k=%0d got en%b we%b %h/%h want write %h/33",
                   k, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, fill_idx);
        end
        fill_idx++;
      end else if (MEM_EN !== 1'b0 || MEM_WE !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_idle_bus k=%0d got en%b we%b want 0 0", k, MEM_EN, MEM_WE);
      end
      vectors++;
      if (DISP_VALID !== exp_v[k] || (exp_v[k] && DISP_DATA !== exp_d[k])) begin
        miscompares++;
        $display("FAIL fill_disp_data k=%0d got %b/%h want %b/%h", k, DISP_VALID, DISP_DATA, exp_v[k], exp_d[k]);
      end
    end
    DISP_REQ = 1'b0;
    vectors++;
    if (CLEAR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_disp_busy_end got %b want 0", CLEAR_BUSY);
    end
    for (int i = 0; i < FRAME_PIXELS; i++) ref_ram[i] = 8'h33;
    repeat (3) step();
  endtask

  task automatic test_reset_mid_fill();
    logic [ADDR_W+19:0] obs;
    clear_log();
    CLEAR_START = 1'b1;
    CLEAR_COLOR = 8'h44;
    step();
    CLEAR_START = 1'b0;
    HOST_VALID  = 1'b1;
    HOST_ADDR   = 10'h300;
    HOST_WDATA  = 8'h5A;
    step();
    HOST_VALID = 1'b0;
    repeat (7) step();
    vectors++;
    if (MEM_WE !== 1'b1 || MEM_ADDR !== 10'd7) begin
      miscompares++;
      $display("FAIL midfill_addr7 got we%b %h want 1 007", MEM_WE, MEM_ADDR);
    end
    DISP_REQ  = 1'b1;
    DISP_ADDR = 10'h100;
    step();
    DISP_REQ = 1'b0;
    step();
    vectors++;
    if (MEM_WE !== 1'b1 || MEM_ADDR !== 10'd8) begin
      miscompares++;
      $display("FAIL midfill_addr8 got we%b %h want 1 008", MEM_WE, MEM_ADDR);
    end
    RST_N = 1'b0;
    step();
    obs = {MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, DISP_VALID, DISP_DATA, CLEAR_BUSY, HOST_READY};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL midfill_reset_outputs got %h want 0", obs);
    end
    step();
    RST_N = 1'b1;
    clear_log();
    for (int k = 0; k < 20; k++) begin
      step();
      vectors++;
      if (MEM_WE !== 1'b0 || DISP_VALID !== 1'b0 || CLEAR_BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet k=%0d got we%b valid%b busy%b want 0 0 0", k, MEM_WE, DISP_VALID, CLEAR_BUSY);
      end
    end
    vectors++;
    if (wr_addr_q.size() != 0 || HOST_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_writes got %0d writes ready %b want 0 1", wr_addr_q.size(), HOST_READY);
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_SIZE; i++) begin
      ram[i]     = 8'h00;
      ref_ram[i] = 8'h00;
    end
    idle_inputs();
    RST_N = 1'b0;
    test_reset();
    test_disp_read();
    test_random_reads();
    test_fifo_full();
    test_random_host();
    test_clear();
    test_host_during_fill();
    test_fill_with_display();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, pixel-RAM address width.
REQ-002 SHALL have parameter FRAME_PIXELS, default 307200, pixels per frame (640x480).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, host write buffer entries (power of 2).
REQ-004 SHALL have port PIX_CLK  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port DISP_REQ  in  1  scanout read request (active video).
REQ-007 SHALL have port DISP_ADDR  in  ADDR_W  scanout read address.
REQ-008 SHALL have port DISP_DATA  out  8  read pixel, RRRGGGBB packing as PIX_DATA.
REQ-009 SHALL have port DISP_VALID  out  1  DISP_DATA valid strobe.
REQ-010 SHALL have port HOST_VALID  in  1  host write offered.
REQ-011 SHALL have port HOST_READY  out  1  host write accepted when high with HOST_VALID.
REQ-012 SHALL have ports HOST_ADDR  in  ADDR_W and HOST_WDATA  in  8  host write address/pixel.
REQ-013 SHALL have ports CLEAR_START  in  1 (pulse) and CLEAR_COLOR  in  8  frame fill request/colour.
REQ-014 SHALL have port CLEAR_BUSY  out  1  fill in progress.
REQ-015 SHALL have ports MEM_EN, MEM_WE  out  1; MEM_ADDR  out  ADDR_W; MEM_WDATA  out  8; MEM_RDATA  in  8  single-port RAM, 1-cycle read latency.

Function
REQ-016 SHALL grant RAM per cycle by fixed priority: display > clear > host FIFO drain.
REQ-017 SHALL register all MEM_* outputs: request sampled cycle t drives RAM in cycle t+1.
REQ-018 SHALL assert DISP_VALID with DISP_DATA=MEM_RDATA exactly 2 cycles after DISP_REQ sampled high; every DISP_REQ served, no stalls.
REQ-019 SHALL accept a host write when HOST_VALID and HOST_READY are high; HOST_READY = FIFO not full, from registered count.
REQ-020 SHALL refuse a push to a full FIFO even if a pop occurs the same cycle.
REQ-021 SHALL pop one FIFO entry per cycle when FIFO non-empty, DISP_REQ low and FSM in IDLE; writes retire in acceptance order.
REQ-022 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on CLEAR_START, CLEAR->IDLE after address FRAME_PIXELS-1 written.
REQ-023 SHALL, in CLEAR, latch CLEAR_COLOR at start and write addresses 0..FRAME_PIXELS-1 ascending, one per non-display cycle; counter holds while DISP_REQ high.
REQ-024 SHALL hold CLEAR_BUSY high from the cycle after CLEAR_START through the final fill write.
REQ-025 SHALL ignore CLEAR_START while CLEAR_BUSY high.
REQ-026 SHALL keep accepting host writes during CLEAR but not drain them until IDLE, so they land over the fill.
REQ-027 SHALL perform no read-after-write forwarding; display reads return RAM contents.
REQ-028 SHALL drive MEM_EN low and MEM_WE low on cycles with no grant.

Reset
REQ-029 SHALL, while RST_N low at a clock edge, force MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, DISP_VALID=0, DISP_DATA=0, CLEAR_BUSY=0, HOST_READY=0, FSM=IDLE, FIFO empty, fill counter 0.
REQ-030 SHALL raise HOST_READY in the first cycle after RST_N high.
REQ-031 SHALL abort an in-progress fill and discard buffered writes on reset; in-flight DISP_VALID suppressed.

Structure
REQ-032 SHALL take ADDR_W, FRAME_PIXELS, FIFO_DEPTH defaults and the IDLE/CLEAR state type from shared package vga_pkg.
REQ-033 SHALL place the host write buffer in one sub-module vram_wr_fifo (push/pop/full/empty/count).

Verification
REQ-034 SHALL check: DISP_REQ=1, DISP_ADDR=0x00100, RAM[0x100]=0xA5 -> DISP_VALID=1, DISP_DATA=0xA5 two cycles later.
REQ-035 SHALL check: 5 back-to-back host writes while DISP_REQ=1 -> 4 accepted, HOST_READY=0 on fifth; after DISP_REQ=0, 4 writes retire in order in 4 cycles.
REQ-036 SHALL check: CLEAR_START, CLEAR_COLOR=0xE0, FRAME_PIXELS=16 override, no display -> 16 writes addr 0..15 data 0xE0, CLEAR_BUSY falls after addr 15.
REQ-037 SHALL check: host write 0x07 to addr 3 during fill -> final RAM[3]=0x07.
REQ-038 SHALL check: DISP_REQ alternating 1/0 during fill -> fill addresses advance only on DISP_REQ=0 cycles, no display read missed.
REQ-039 SHALL check: RST_N low mid-fill at addr 8 -> all outputs at reset values next edge, no further MEM_WE.
